// File: rtl/keypad_pkg.sv
// Shared types, key codes and helpers for the keypad entry block.
// Edit helpers work directly on the signed BCD display word.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    localparam logic [3:0] KEY_SIGN  = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;
    localparam logic [3:0] KEY_BKSP  = 4'd12;
    localparam logic [3:0] ROW_RESET = 4'b1110;

    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

    // True when exactly one bit of an active-low vector is asserted.
    function automatic logic one_cold(input logic [3:0] v);
        logic res;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] cold_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [15:0] edit_data(input logic [15:0] d, input logic [3:0] code);
        logic [15:0] res;
        res = d;
        if (code <= 4'd9) begin
            res = {d[15:12], d[7:4], d[3:0], code};
        end else if (code == KEY_SIGN) begin
            res = {d[15:12] ^ 4'd1, d[11:0]};
        end else if (code == KEY_CLEAR) begin
            res = 16'h0000;
        end else if (code == KEY_BKSP) begin
            res = {d[15:12], 4'd0, d[11:8], d[7:4]};
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad matrix and display-word signals between the entry block and its surroundings.
interface keypad_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] data;
    logic        key_valid;
    logic [3:0]  key_code;

    modport master (
        output row,
        output data,
        output key_valid,
        output key_code,
        input  col
    );

    modport slave (
        input  row,
        input  data,
        input  key_valid,
        input  key_code,
        output col
    );
endinterface

// File: rtl/keypad_tick.sv
// Scan prescaler: counts 0..SCAN_DIV and pulses tick for one clk at the top value.
module keypad_tick #(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned PW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;

    logic [PW-1:0] pre_q, pre_d;

    // SCAN_DIV=0 collapses to a permanent tick.
    assign tick = (pre_q == PW'(SCAN_DIV));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with per-key debounce that edits a signed 3-digit BCD display word.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 20000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input logic            clk,
    input logic            rst,
    keypad_entry_if.master bus
);

    localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);

    logic          tick;
    logic [3:0]    sync_q, col_s_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cap_q, cap_d;
    logic [3:0]    row_q, row_d;
    logic [15:0]   data_q, data_d;
    logic          kv_q, kv_d;
    logic [3:0]    code_q, code_d;
    logic [3:0]    press_col;
    logic [3:0]    press_code;

    keypad_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 4'hF;
            col_s_q <= 4'hF;
        end else begin
            sync_q  <= bus.col;
            col_s_q <= sync_q;
        end
    end

    // With a one-tick debounce the press is accepted straight from SCAN.
    assign press_col  = (state_q == StScan) ? col_s_q : cap_q;
    assign press_code = {cold_idx(row_q), cold_idx(press_col)};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        row_d   = row_q;
        data_d  = data_q;
        kv_d    = 1'b0;
        code_d  = code_q;

        unique case (state_q)
            StScan: begin
                if (tick) begin
                    if (one_cold(col_s_q)) begin
                        cap_d = col_s_q;
                        cnt_d = CW'(1);
                        if (CNT_DONE <= CW'(1)) begin
                            state_d = StPressed;
                            kv_d    = 1'b1;
                            code_d  = press_code;
                            data_d  = edit_data(data_q, press_code);
                        end else begin
                            state_d = StDebounce;
                        end
                    end else begin
                        row_d = rotate_row(row_q);
                    end
                end
            end
            StDebounce: begin
                if (tick) begin
                    if (col_s_q == cap_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CNT_DONE) begin
                            state_d = StPressed;
                            kv_d    = 1'b1;
                            code_d  = press_code;
                            data_d  = edit_data(data_q, press_code);
                        end
                    end else begin
                        state_d = StScan;
                        cnt_d   = '0;
                        row_d   = rotate_row(row_q);
                    end
                end
            end
            StPressed: begin
                state_d = StRelease;
                cnt_d   = '0;
            end
            StRelease: begin
                if (tick) begin
                    if (col_s_q == 4'hF) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CNT_DONE) begin
                            state_d = StScan;
                            cnt_d   = '0;
                            row_d   = rotate_row(row_q);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = StScan;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StScan;
            cnt_q   <= '0;
            cap_q   <= 4'hF;
            row_q   <= ROW_RESET;
            data_q  <= 16'h0000;
            kv_q    <= 1'b0;
            code_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            row_q   <= row_d;
            data_q  <= data_d;
            kv_q    <= kv_d;
            code_q  <= code_d;
        end
    end

    assign bus.row       = row_q;
    assign bus.data      = data_q;
    assign bus.key_valid = kv_q;
    assign bus.key_code  = code_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad matrix model drives col from row, and a decimal
// model of the display value predicts data after every accepted key.
module tb_keypad_entry;

    localparam int unsigned SCAN_DIV = 9;
    localparam int unsigned DB_TICKS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0000;
    logic        force_en = 1'b0;
    logic [3:0]  force_val = 4'hF;
    logic [3:0]  col_model;

    int checks = 0;
    int failures = 0;
    int kv_count = 0;
    int data_viol = 0;
    logic [15:0] prev_data = 16'h0000;

    // Display value model: sign bit plus a 0..999 magnitude.
    int m_sign = 0;
    int m_val = 0;

    keypad_entry_if bus ();

    keypad_entry #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DB_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Key index r*4+c pulls column c low while row r is selected.
    always_comb begin
        col_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (bus.row[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) col_model[c] = 1'b0;
                end
            end
        end
    end

    assign bus.col = force_en ? force_val : col_model;

    always @(negedge clk) begin
        if (bus.key_valid) kv_count <= kv_count + 1;
        if (!rst && (bus.data !== prev_data) && !bus.key_valid) data_viol <= data_viol + 1;
        prev_data <= bus.data;
    end

    function automatic logic [15:0] expected_data();
        logic [3:0] s, h, t, u;
        s = 4'(m_sign);
        h = 4'(m_val / 100);
        t = 4'((m_val / 10) % 10);
        u = 4'(m_val % 10);
        return {s, h, t, u};
    endfunction

    task automatic model_apply(input int code);
        if (code < 10) begin
            m_val = (m_val * 10 + code) % 1000;
        end else if (code == 10) begin
            m_sign = 1 - m_sign;
        end else if (code == 11) begin
            m_val  = 0;
            m_sign = 0;
        end else if (code == 12) begin
            m_val = m_val / 10;
        end
    endtask

    function automatic logic [3:0] next_row(input logic [3:0] r);
        logic [3:0] n;
        case (r)
            4'b1110: n = 4'b1101;
            4'b1101: n = 4'b1011;
            4'b1011: n = 4'b0111;
            4'b0111: n = 4'b1110;
            default: n = 4'bxxxx;
        endcase
        return n;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rotation(input string name);
        logic [3:0] r;
        logic [3:0] exp;
        r = bus.row;
        exp = next_row(r);
        wait_clk(SCAN_DIV + 1);
        checks++;
        if (bus.row !== exp) begin
            failures++;
            $display("FAIL %s: row got %b expected %b", name, bus.row, exp);
        end
    endtask

    task automatic do_press(input logic [3:0] code, input string name);
        int base;
        bit seen;
        logic [15:0] exp;
        base = kv_count;
        seen = 0;
        keys = 16'd1 << code;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.key_valid) seen = 1;
        end
        model_apply(int'(code));
        exp = expected_data();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout: key_valid got none expected one for code %0d", name, code);
        end else begin
            checks++;
            if (bus.key_code !== code) begin
                failures++;
                $display("FAIL %s key_code: got %h expected %h", name, bus.key_code, code);
            end
            checks++;
            if (bus.data !== exp) begin
                failures++;
                $display("FAIL %s data: got %h expected %h", name, bus.data, exp);
            end
        end
        keys = 16'h0000;
        wait_clk(80);
        checks++;
        if (kv_count - base != 1) begin
            failures++;
            $display("FAIL %s events: got %0d expected 1", name, kv_count - base);
        end
        checks++;
        if (bus.data !== exp || bus.key_code !== code) begin
            failures++;
            $display("FAIL %s hold: got data %h code %h expected %h %h",
                     name, bus.data, bus.key_code, exp, code);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        checks++;
        if (bus.row !== 4'b1110 || bus.data !== 16'h0000 || bus.key_valid !== 1'b0 ||
            bus.key_code !== 4'h0) begin
            failures++;
            $display("FAIL reset_values: got row %b data %h kv %b code %h expected 1110 0000 0 0",
                     bus.row, bus.data, bus.key_valid, bus.key_code);
        end
        rst = 1'b0;
        wait_clk(SCAN_DIV);
        checks++;
        if (bus.row !== 4'b1110) begin
            failures++;
            $display("FAIL reset_hold_row: got %b expected 1110", bus.row);
        end
        wait_clk(1);
        checks++;
        if (bus.row !== 4'b1101) begin
            failures++;
            $display("FAIL reset_first_rotate: got %b expected 1101", bus.row);
        end
        for (int i = 0; i < 4; i++) check_rotation("reset_scan_rotate");
    endtask

    task automatic test_digit_entry();
        do_press(4'd6, "digit_6");
        do_press(4'd5, "digit_5");
        do_press(4'd3, "digit_3");
        do_press(4'd9, "digit_9");
    endtask

    task automatic test_edit_keys();
        do_press(4'd10, "edit_sign");
        do_press(4'd10, "edit_sign_back");
        do_press(4'd12, "edit_bksp");
        do_press(4'd11, "edit_clear");
        do_press(4'd14, "edit_nop14");
    endtask

    task automatic test_bounce();
        int base;
        logic [15:0] d0;
        base = kv_count;
        d0 = bus.data;
        force_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            force_val = 4'b1110;
            wait_clk(SCAN_DIV + 1);
            force_val = 4'b1111;
            wait_clk(SCAN_DIV + 1);
        end
        wait_clk(60);
        force_en = 1'b0;
        checks++;
        if (kv_count != base || bus.data !== d0) begin
            failures++;
            $display("FAIL bounce: got events %0d data %h expected 0 %h", kv_count - base,
                     bus.data, d0);
        end
        check_rotation("bounce_rotate");
    endtask

    task automatic test_held_key();
        int base;
        bit seen;
        base = kv_count;
        seen = 0;
        keys = 16'd1 << 3;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (bus.key_valid) seen = 1;
        end
        model_apply(3);
        wait_clk(50 * (SCAN_DIV + 1));
        checks++;
        if (kv_count - base != 1) begin
            failures++;
            $display("FAIL held_key events: got %0d expected 1", kv_count - base);
        end
        checks++;
        if (bus.data !== expected_data()) begin
            failures++;
            $display("FAIL held_key data: got %h expected %h", bus.data, expected_data());
        end
        keys = 16'h0000;
        wait_clk(80);
    endtask

    task automatic test_ghosting();
        int base;
        base = kv_count;
        force_en = 1'b1;
        force_val = 4'b1100;
        wait_clk(100);
        check_rotation("ghost_rotate");
        check_rotation("ghost_rotate2");
        checks++;
        if (kv_count != base) begin
            failures++;
            $display("FAIL ghost_events: got %0d expected 0", kv_count - base);
        end
        force_en = 1'b0;
        wait_clk(20);
    endtask

    task automatic test_random();
        logic [3:0] code;
        for (int i = 0; i < 10; i++) begin
            code = 4'($urandom_range(15, 0));
            do_press(code, "random_key");
        end
    endtask

    task automatic test_reset_mid_debounce();
        bit found;
        int first;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.row == 4'b1110) found = 1;
        end
        keys = 16'd1 << 5;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.row == 4'b1101) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_reset_row_wait: got row %b expected 1101", bus.row);
        end
        // Capture at the next tick, cnt=2 after the one following.
        wait_clk(25);
        rst = 1'b1;
        #1;
        m_val  = 0;
        m_sign = 0;
        checks++;
        if (bus.row !== 4'b1110 || bus.data !== 16'h0000 || bus.key_valid !== 1'b0 ||
            bus.key_code !== 4'h0) begin
            failures++;
            $display("FAIL mid_reset_values: got row %b data %h kv %b code %h expected 1110 0000 0 0",
                     bus.row, bus.data, bus.key_valid, bus.key_code);
        end
        wait_clk(3);
        rst = 1'b0;
        first = -1;
        for (int i = 1; i <= 120 && first < 0; i++) begin
            @(negedge clk);
            if (bus.key_valid) first = i;
        end
        checks++;
        if (first != 5 * (SCAN_DIV + 1)) begin
            failures++;
            $display("FAIL mid_reset_latency: got key_valid at clk %0d expected %0d", first,
                     5 * (SCAN_DIV + 1));
        end
        model_apply(5);
        checks++;
        if (bus.key_code !== 4'd5 || bus.data !== expected_data()) begin
            failures++;
            $display("FAIL mid_reset_press: got code %h data %h expected 5 %h", bus.key_code,
                     bus.data, expected_data());
        end
        keys = 16'h0000;
        wait_clk(80);
    endtask

    initial begin
        test_reset();
        test_digit_entry();
        test_edit_keys();
        test_bounce();
        test_held_key();
        test_ghosting();
        test_random();
        test_reset_mid_debounce();
        checks++;
        if (data_viol != 0) begin
            failures++;
            $display("FAIL data_only_with_key_valid: got %0d stray changes expected 0", data_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 active-low matrix keypad, debounces one key at a time and edits a 16-bit signed BCD display word. It is the input-side counterpart of the 4-digit multiplexed seven-segment driver. Its `data` output connects directly to that driver's `data` input: sign nibble, then decade, unit and tenth digits. The block also emits a one-cycle key event for other consumers.

## Interface
- `SCAN_DIV`, default 20000: the scan tick fires when the prescaler equals `SCAN_DIV`, which gives a period of `SCAN_DIV+1` clk cycles.
- `DEBOUNCE_TICKS`, default 4: the number of consecutive stable ticks required to accept a press or a release.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `row`  out  4  row drive, one-hot active-low; the selected row is driven 0.
- `col`  in  4  column sense, active-low with pull-ups, asynchronous to `clk`.
- `data`  out  16  `[15:12]` sign (0 = plus, 1 = minus), `[11:8]` decade, `[7:4]` unit, `[3:0]` tenth, all BCD.
- `key_valid`  out  1  one-clk pulse per accepted key press.
- `key_code`  out  4  `{row_idx[1:0], col_idx[1:0]}` of the last accepted key; held between events.

## Operation
- `col` passes through a 2-flop synchronizer, giving `col_s`. All decisions use `col_s`, sampled only on ticks.
- The prescaler counts 0..`SCAN_DIV` and then wraps to 0. `tick` is high for one clk at `SCAN_DIV`.
- The FSM has four states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- **SCAN**, on tick:
  - If `col_s` has exactly one bit low, capture `col_s`, set cnt=1 and go to DEBOUNCE. `row` is held.
  - Otherwise (none low, or 2 or more low as ghosting) rotate `row` to the next row: 1110 → 1101 → 1011 → 0111 → 1110.
- **DEBOUNCE**, on tick:
  - If `col_s` equals the captured value, cnt+1. When cnt reaches `DEBOUNCE_TICKS`, go to PRESSED.
  - On mismatch, go to SCAN and rotate `row`.
- **PRESSED** lasts exactly one clk:
  - `key_valid`=1, `key_code` is loaded and `data` is edited.
  - Then go to RELEASE with cnt=0.
- **RELEASE**, on tick:
  - If `col_s`==4'hF, cnt+1; otherwise cnt=0.
  - When cnt reaches `DEBOUNCE_TICKS`, go to SCAN and rotate `row`.
  - A held key produces exactly one event.
- Edit rules by code; each nibble stays in 0..9 and sign stays in 0..1.
  - Codes 0–9 (digit d): tenth←d, unit←old tenth, decade←old unit. The old decade is discarded. Sign is unchanged.
  - Code 10: sign ← sign XOR 1.
  - Code 11: data←16'h0000 (clear).
  - Code 12: backspace. tenth←unit, unit←decade, decade←0. Sign is unchanged.
  - Codes 13–15: `key_valid` pulses and `key_code` updates, but `data` is unchanged.

## Timing
- Reset values:
  - `row`=4'b1110
  - `data`=16'h0000
  - `key_valid`=0
  - `key_code`=4'h0
  - FSM in SCAN, prescaler=0, cnt=0
  - synchronizer flops = 4'hF
- `row`, `data`, `key_valid` and `key_code` are all registered outputs.
- `data` changes only in the same clk in which `key_valid`=1.
- Press latency: a press first seen at tick T0 produces `key_valid` one clk after tick T0+(`DEBOUNCE_TICKS`−1). Add 2 clk of synchronizer delay relative to the `col` edge.
- A column change during DEBOUNCE aborts the press. No partial event is emitted.
- Reset asserted mid-operation (any state) returns everything to reset values on the next evaluation. No `key_valid` is emitted while `rst` is high or in the clk after release of reset.
- With `SCAN_DIV`=0, a tick occurs every clk. This must be legal.

## Structure
- Package `keypad_pkg` contains:
  - the FSM state enum (SCAN, DEBOUNCE, PRESSED, RELEASE)
  - `KEY_SIGN`=4'd10, `KEY_CLEAR`=4'd11, `KEY_BKSP`=4'd12
  - the reset row constant 4'b1110
- Sub-module `keypad_tick` contains the parameterized prescaler and produces `tick`.
- The synchronizer, FSM and edit datapath stay in `keypad_entry`.

## Test plan
All scenarios use `SCAN_DIV`=9 and `DEBOUNCE_TICKS`=4.
- **Reset:** assert `rst` → `row`=1110, `data`=0000, `key_valid`=0. Release → `row` rotates every 10 clk with no key pressed.
- **Digit entry:** model a stable press at row1/col2, giving code 6 → one `key_valid`, `key_code`=6, `data`=16'h0006. Release, then press 5, 3, 9 → `data` goes 0065, 0653, 0539.
- **Edit keys:** start from 0539.
  - Code 10 → 1539; code 10 again → 0539.
  - Code 12 → 0053.
  - Code 11 → 0000.
  - Code 14 → `key_valid` pulses and `data` is unchanged.
- **Bounce:** toggle `col` for 2 ticks and then release → no `key_valid`, `data` unchanged, scan resumes.
- **Held key and ghosting:**
  - Hold code 3 for 50 ticks → exactly one `key_valid`.
  - Drive two columns low → no `key_valid`, and `row` keeps rotating.
- **Reset mid-debounce:** assert `rst` at debounce cnt=2 → all outputs return to reset values, and no `key_valid` occurs after reset is released while the key is still held until a full debounce completes.
